id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID and EXE stages of the ARM core.
- Captures decoded controls and operands each cycle and inserts a bubble when hazard detection fires, when a taken branch flushes, or when ID has no valid instruction.
- Holds its contents on a memory freeze.
- Its registered dest/WB_EN outputs are the Exe_Dest/Exe_WB_EN inputs of hazard detection; src1/src2 outputs feed forwarding.

Parameters:
- DATA_W, 32, operand and PC width
- CNT_W, 16, width of the optional performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  memory stall; hold all state
- flush  in  1  branch taken in EXE; squash the ID instruction
- hazard_detected  in  1  from hazard detection; insert a bubble
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC+4 of the ID instruction
- id_val_rn, id_val_rm  in  DATA_W  register file read data
- id_shift_operand  in  12  shifter operand field
- id_imm24  in  24  signed branch offset
- id_dest, id_src1, id_src2  in  4  register indices
- id_exe_cmd  in  4  ALU command
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  control bits
- id_status  in  4  NZCV snapshot
- exe_* outputs  out  same widths as the id_* inputs  registered copies
- exe_valid  out  1  EXE slot holds a real instruction
- bubble_cnt, flush_cnt, freeze_cnt  out  CNT_W each  only when the optional feature is enabled

Behaviour:
- Reset (rst_n low, asynchronous): every exe_* output is 0 and exe_valid is 0 immediately, independent of clk. Release is synchronous to the next clk edge.
- Latency: 1 cycle from ID inputs to exe_* outputs.
- Per-edge priority, highest first:
  1. freeze=1: hold every register, regardless of flush, hazard_detected or id_valid.
  2. flush=1: load bubble.
  3. hazard_detected=1: load bubble.
  4. id_valid=0: load bubble.
  5. Otherwise: load all id_* fields and set exe_valid=1.
- Bubble definition: all exe_* fields = 0, including data, dest and src fields, and exe_valid = 0. As a result exe_wb_en = 0, so hazard detection sees no EXE writer.
- flush and hazard_detected in the same cycle: one bubble, attributed to flush.
- The block does not itself freeze upstream. IF/ID stalls on hazard_detected externally; this block only bubbles.
- Consecutive hazard cycles produce consecutive bubbles. There is no limit.
- exe_mem_r_en and exe_mem_w_en are never both 1 unless both inputs are 1. No checking is done; the values pass through.

Optional Feature:
- Macro: ID_EXE_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on each edge where a bubble is loaded due to hazard_detected (flush=0, freeze=0).
  - flush_cnt increments on each flush bubble (freeze=0).
  - freeze_cnt increments on each frozen edge.
  - All counters saturate at 2^CNT_W-1 and reset to 0 on rst_n.
  - Counters stay live during freeze; only freeze_cnt changes.
- Undefined: the counter ports and logic are absent. The pipeline behaviour is identical.

Decomposition:
- Package arm_pipe_pkg:
  - EXE_CMD_W=4, REG_IDX_W=4, SHIFT_OP_W=12, IMM24_W=24
  - Struct id_exe_ctrl_t (wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd)
  - Constant ID_EXE_BUBBLE, the all-zero control value
- One sub-module, pipe_reg_hold_clr: a parameterised-width register with async active-low reset, hold enable and synchronous clear. It is instantiated for the control struct, the operand group and the valid bit.

Test Plan:
- Reset mid-stream: load instruction with wb_en=1, dest=3; pulse rst_n low between edges -> outputs 0 immediately, exe_valid=0.
- Normal flow: id_valid=1, exe_cmd=4'b0010, dest=5, val_rn=0x10 -> next edge exe_dest=5, exe_val_rn=0x10, exe_valid=1.
- Hazard bubble: hazard_detected=1 with id_wb_en=1, dest=7 -> exe_wb_en=0, exe_dest=0, exe_valid=0; bubble_cnt increments by 1 when the feature is enabled.
- Freeze over flush and hazard: previous exe_dest=9; freeze=1, flush=1, hazard_detected=1 for 3 cycles -> outputs unchanged at dest=9; freeze_cnt=3, flush_cnt=0.
- Flush with hazard: flush=1, hazard_detected=1 -> one bubble; flush_cnt+1, bubble_cnt unchanged.
- Saturation: CNT_W=2; 5 hazard bubbles -> bubble_cnt=3.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared types and widths for the ARM core pipeline registers.
// Holds the ID/EXE control struct and its all-zero bubble value.
package arm_pipe_pkg;

    localparam int EXE_CMD_W  = 4;
    localparam int REG_IDX_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int STATUS_W   = 4;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic                 imm;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } id_exe_ctrl_t;

    localparam int CTRL_W = $bits(id_exe_ctrl_t);

    localparam id_exe_ctrl_t ID_EXE_BUBBLE = '{
        wb_en:    1'b0,
        mem_r_en: 1'b0,
        mem_w_en: 1'b0,
        b:        1'b0,
        s:        1'b0,
        imm:      1'b0,
        exe_cmd:  {EXE_CMD_W{1'b0}}
    };

endpackage

// File: rtl/pipe_reg_hold_clr.sv
// Parameterised pipeline register: async active-low reset, hold enable
// (highest priority) and synchronous clear to zero.
module pipe_reg_hold_clr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_hold,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // State update: hold beats clear, clear beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {W{1'b0}};
        end else if (i_hold) begin
            r_q <= r_q;
        end else if (i_clr) begin
            r_q <= {W{1'b0}};
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the ARM core: loads bubbles on flush, hazard or
// an empty ID slot, holds on freeze. Optional counters under ID_EXE_PERF_CNT_EN.
module id_exe_stage_reg
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  hazard_detected,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_val_rn,
    input  logic [DATA_W-1:0]     id_val_rm,
    input  logic [SHIFT_OP_W-1:0] id_shift_operand,
    input  logic [IMM24_W-1:0]    id_imm24,
    input  logic [REG_IDX_W-1:0]  id_dest,
    input  logic [REG_IDX_W-1:0]  id_src1,
    input  logic [REG_IDX_W-1:0]  id_src2,
    input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic                  id_imm,
    input  logic [STATUS_W-1:0]   id_status,
    output logic [DATA_W-1:0]     exe_pc,
    output logic [DATA_W-1:0]     exe_val_rn,
    output logic [DATA_W-1:0]     exe_val_rm,
    output logic [SHIFT_OP_W-1:0] exe_shift_operand,
    output logic [IMM24_W-1:0]    exe_imm24,
    output logic [REG_IDX_W-1:0]  exe_dest,
    output logic [REG_IDX_W-1:0]  exe_src1,
    output logic [REG_IDX_W-1:0]  exe_src2,
    output logic [EXE_CMD_W-1:0]  exe_exe_cmd,
    output logic                  exe_wb_en,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic                  exe_b,
    output logic                  exe_s,
    output logic                  exe_imm,
    output logic [STATUS_W-1:0]   exe_status,
    output logic                  exe_valid
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      freeze_cnt
`endif
);

    localparam int OPS_W = 3*DATA_W + SHIFT_OP_W + IMM24_W + 3*REG_IDX_W + STATUS_W;

    logic               w_bubble;
    id_exe_ctrl_t       w_ctrl_d;
    id_exe_ctrl_t       w_ctrl_q;
    logic [CTRL_W-1:0]  w_ctrl_q_bits;
    logic [OPS_W-1:0]   w_ops_d;
    logic [OPS_W-1:0]   w_ops_q;
    logic               w_valid_q;

    // Any of these squashes the ID instruction; freeze is handled as hold.
    assign w_bubble = flush | hazard_detected | ~id_valid;

    // Control fields collapse to the bubble value so exe_wb_en can never leak.
    always_comb begin
        w_ctrl_d = ID_EXE_BUBBLE;
        if (w_bubble) begin
            w_ctrl_d = ID_EXE_BUBBLE;
        end else begin
            w_ctrl_d.wb_en    = id_wb_en;
            w_ctrl_d.mem_r_en = id_mem_r_en;
            w_ctrl_d.mem_w_en = id_mem_w_en;
            w_ctrl_d.b        = id_b;
            w_ctrl_d.s        = id_s;
            w_ctrl_d.imm      = id_imm;
            w_ctrl_d.exe_cmd  = id_exe_cmd;
        end
    end

    assign w_ops_d = {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm24,
                      id_dest, id_src1, id_src2, id_status};

    pipe_reg_hold_clr #(.W(CTRL_W)) u_ctrl_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (freeze),
        .i_clr  (w_bubble),
        .i_d    (w_ctrl_d),
        .o_q    (w_ctrl_q_bits)
    );

    pipe_reg_hold_clr #(.W(OPS_W)) u_ops_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (freeze),
        .i_clr  (w_bubble),
        .i_d    (w_ops_d),
        .o_q    (w_ops_q)
    );

    pipe_reg_hold_clr #(.W(1)) u_valid_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hold (freeze),
        .i_clr  (w_bubble),
        .i_d    (1'b1),
        .o_q    (w_valid_q)
    );

    assign w_ctrl_q = id_exe_ctrl_t'(w_ctrl_q_bits);

    assign exe_wb_en    = w_ctrl_q.wb_en;
    assign exe_mem_r_en = w_ctrl_q.mem_r_en;
    assign exe_mem_w_en = w_ctrl_q.mem_w_en;
    assign exe_b        = w_ctrl_q.b;
    assign exe_s        = w_ctrl_q.s;
    assign exe_imm      = w_ctrl_q.imm;
    assign exe_exe_cmd  = w_ctrl_q.exe_cmd;

    assign {exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_imm24,
            exe_dest, exe_src1, exe_src2, exe_status} = w_ops_q;

    assign exe_valid = w_valid_q;

`ifdef ID_EXE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    // Saturating event counters; each edge is attributed to one cause only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= {CNT_W{1'b0}};
            r_flush_cnt  <= {CNT_W{1'b0}};
            r_freeze_cnt <= {CNT_W{1'b0}};
        end else if (freeze) begin
            if (r_freeze_cnt != CNT_MAX) begin
                r_freeze_cnt <= r_freeze_cnt + CNT_ONE;
            end else begin
                r_freeze_cnt <= r_freeze_cnt;
            end
        end else if (flush) begin
            if (r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end else if (hazard_detected) begin
            if (r_bubble_cnt != CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end else begin
                r_bubble_cnt <= r_bubble_cnt;
            end
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
            r_flush_cnt  <= r_flush_cnt;
            r_freeze_cnt <= r_freeze_cnt;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;
`else
    // CNT_W only sizes the counters; without them it still has to be sane.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg; counter checks apply when
// ID_EXE_PERF_CNT_EN is defined (counters built with CNT_W=2).
module tb_id_exe_stage_reg;
    import arm_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  freeze, flush, hazard_detected, id_valid;
    logic [DATA_W-1:0]     id_pc, id_val_rn, id_val_rm;
    logic [SHIFT_OP_W-1:0] id_shift_operand;
    logic [IMM24_W-1:0]    id_imm24;
    logic [REG_IDX_W-1:0]  id_dest, id_src1, id_src2;
    logic [EXE_CMD_W-1:0]  id_exe_cmd;
    logic                  id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm;
    logic [STATUS_W-1:0]   id_status;
    logic [DATA_W-1:0]     exe_pc, exe_val_rn, exe_val_rm;
    logic [SHIFT_OP_W-1:0] exe_shift_operand;
    logic [IMM24_W-1:0]    exe_imm24;
    logic [REG_IDX_W-1:0]  exe_dest, exe_src1, exe_src2;
    logic [EXE_CMD_W-1:0]  exe_exe_cmd;
    logic                  exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm;
    logic [STATUS_W-1:0]   exe_status;
    logic                  exe_valid;
`ifdef ID_EXE_PERF_CNT_EN
    logic [CNT_W-1:0]      bubble_cnt, flush_cnt, freeze_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .hazard_detected(hazard_detected), .id_valid(id_valid),
        .id_pc(id_pc), .id_val_rn(id_val_rn), .id_val_rm(id_val_rm),
        .id_shift_operand(id_shift_operand), .id_imm24(id_imm24),
        .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
        .id_exe_cmd(id_exe_cmd), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .id_mem_w_en(id_mem_w_en), .id_b(id_b), .id_s(id_s), .id_imm(id_imm),
        .id_status(id_status),
        .exe_pc(exe_pc), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
        .exe_shift_operand(exe_shift_operand), .exe_imm24(exe_imm24),
        .exe_dest(exe_dest), .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_exe_cmd(exe_exe_cmd), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm),
        .exe_status(exe_status), .exe_valid(exe_valid)
`ifdef ID_EXE_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] dest, input logic wb, input logic [31:0] rn);
        id_valid = 1'b1; id_dest = dest; id_wb_en = wb; id_val_rn = rn;
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; flush = 1'b0; hazard_detected = 1'b0;
        id_valid = 1'b1; id_pc = 32'h0000_1234; id_val_rn = 32'h0000_0001;
        id_val_rm = 32'h0000_0002; id_shift_operand = 12'h0FF; id_imm24 = 24'h00_0010;
        id_dest = 4'd3; id_src1 = 4'd1; id_src2 = 4'd2; id_exe_cmd = 4'b0001;
        id_wb_en = 1'b1; id_mem_r_en = 1'b0; id_mem_w_en = 1'b0;
        id_b = 1'b0; id_s = 1'b0; id_imm = 1'b0; id_status = 4'b0000;

        // Reset held across an edge
        #2;
        check("rst_valid", 64'(exe_valid), 64'd0);
        check("rst_dest", 64'(exe_dest), 64'd0);
        step();
        check("rst_edge_wb", 64'(exe_wb_en), 64'd0);
        #2 rst_n = 1'b1;

        // Load wb_en=1 dest=3, then async reset mid-cycle
        step();
        check("load_dest3", 64'(exe_dest), 64'd3);
        check("load_wb", 64'(exe_wb_en), 64'd1);
        check("load_valid", 64'(exe_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_dest", 64'(exe_dest), 64'd0);
        check("async_wb", 64'(exe_wb_en), 64'd0);
        check("async_valid", 64'(exe_valid), 64'd0);
        check("async_pc", 64'(exe_pc), 64'd0);
        #2 rst_n = 1'b1;

        // Normal flow
        load(4'd5, 1'b1, 32'h0000_0010);
        id_exe_cmd = 4'b0010; id_pc = 32'h0000_0104; id_val_rm = 32'h0000_ABCD;
        id_shift_operand = 12'h5A3; id_imm24 = 24'hFF_FFFE; id_src1 = 4'd2;
        id_src2 = 4'd6; id_status = 4'b1010; id_s = 1'b1;
        step();
        check("norm_dest", 64'(exe_dest), 64'd5);
        check("norm_rn", 64'(exe_val_rn), 64'h10);
        check("norm_cmd", 64'(exe_exe_cmd), 64'h2);
        check("norm_valid", 64'(exe_valid), 64'd1);
        check("norm_rm", 64'(exe_val_rm), 64'hABCD);
        check("norm_shift", 64'(exe_shift_operand), 64'h5A3);
        check("norm_imm24", 64'(exe_imm24), 64'hFFFFFE);
        check("norm_srcs", 64'({exe_src1, exe_src2}), 64'h26);
        check("norm_status", 64'(exe_status), 64'hA);
        check("norm_s", 64'(exe_s), 64'd1);

        // Hazard bubble
        load(4'd7, 1'b1, 32'h0000_0077);
        hazard_detected = 1'b1;
        step();
        check("haz_wb", 64'(exe_wb_en), 64'd0);
        check("haz_dest", 64'(exe_dest), 64'd0);
        check("haz_valid", 64'(exe_valid), 64'd0);
        check("haz_rn", 64'(exe_val_rn), 64'd0);
        check("haz_pc", 64'(exe_pc), 64'd0);
`ifdef ID_EXE_PERF_CNT_EN
        check("haz_bcnt", 64'(bubble_cnt), 64'd1);
`endif
        hazard_detected = 1'b0;

        // Empty ID slot
        id_valid = 1'b0;
        step();
        check("noval_valid", 64'(exe_valid), 64'd0);
        check("noval_dest", 64'(exe_dest), 64'd0);

        // Load dest=9, then freeze over flush and hazard for 3 edges
        load(4'd9, 1'b1, 32'h0000_0099);
        step();
        check("pre_frz_dest", 64'(exe_dest), 64'd9);
        freeze = 1'b1; flush = 1'b1; hazard_detected = 1'b1;
        load(4'd4, 1'b0, 32'h0000_0044);
        step();
        step();
        step();
        check("frz_dest", 64'(exe_dest), 64'd9);
        check("frz_rn", 64'(exe_val_rn), 64'h99);
        check("frz_valid", 64'(exe_valid), 64'd1);
        check("frz_wb", 64'(exe_wb_en), 64'd1);
`ifdef ID_EXE_PERF_CNT_EN
        check("frz_fcnt", 64'(freeze_cnt), 64'd3);
        check("frz_flcnt", 64'(flush_cnt), 64'd0);
`endif

        // Flush with hazard: single bubble attributed to flush
        freeze = 1'b0;
        step();
        check("flush_valid", 64'(exe_valid), 64'd0);
        check("flush_wb", 64'(exe_wb_en), 64'd0);
`ifdef ID_EXE_PERF_CNT_EN
        check("flush_flcnt", 64'(flush_cnt), 64'd1);
        check("flush_bcnt", 64'(bubble_cnt), 64'd1);
`endif
        flush = 1'b0; hazard_detected = 1'b0;

        // Both memory enables pass through untouched
        load(4'd11, 1'b0, 32'h0000_00BB);
        id_mem_r_en = 1'b1; id_mem_w_en = 1'b1; id_b = 1'b1; id_imm = 1'b1;
        step();
        check("mem_both", 64'({exe_mem_r_en, exe_mem_w_en}), 64'h3);
        check("b_imm", 64'({exe_b, exe_imm}), 64'h3);
        check("mem_dest", 64'(exe_dest), 64'd11);

        // Five consecutive hazard bubbles, counter saturates
        hazard_detected = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("haz_run_valid", 64'(exe_valid), 64'd0);
        end
`ifdef ID_EXE_PERF_CNT_EN
        check("sat_bcnt", 64'(bubble_cnt), 64'd3);
`endif
        hazard_detected = 1'b0;

        // Recover to normal load after bubbles
        step();
        check("recover_dest", 64'(exe_dest), 64'd11);
        check("recover_valid", 64'(exe_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
